// File: rtl/miner_pkg.sv
// Shared definitions for the mining front-end: frame receiver state encoding,
// error codes reported on err_code, and default frame geometry.
package miner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_TGT  = 3'd2,
        ST_CSUM = 3'd3,
        ST_HOLD = 3'd4
    } rx_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    localparam int         HEADER_BYTES_DEF = 80;
    localparam int         TARGET_BYTES_DEF = 32;
    localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle timer. Counts enabled cycles with no clear, saturates at
// TIMEOUT_CYCLES, and flags expiry combinationally on the cycle whose edge
// would bring the count to TIMEOUT_CYCLES, so the consumer can register its
// error exactly TIMEOUT_CYCLES clocks after the last byte. A clear in the
// same cycle always wins over expiry.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: cleared when idle or on a byte, otherwise saturating increment
    always_comb begin
        count_d = count_q;
        if (clr_i || !en_i) begin
            count_d = '0;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Idle counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && !clr_i && (count_q >= CNT_FIRE);

endmodule

// File: rtl/header_frame_rx.sv
// Host frame parser: SYNC, header bytes, target bytes and (optionally) a
// checksum byte are assembled into one parallel job on a valid/ready port.
// Optional feature macro: HDR_RX_CHECKSUM_EN adds the CSUM state and the
// 8-bit wrapping sum; without it TGT goes straight to HOLD.
//
// state | meaning
// IDLE  | hunting for SYNC_BYTE, other bytes ignored
// HDR   | shifting header bytes, idle timeout armed
// TGT   | shifting target bytes, idle timeout armed
// CSUM  | waiting for checksum byte (checksum builds only)
// HOLD  | job_valid high, waiting for job_ready; any byte is an overrun
module header_frame_rx
    import miner_pkg::*;
#(
    parameter int         HEADER_BYTES   = HEADER_BYTES_DEF,
    parameter int         TARGET_BYTES   = TARGET_BYTES_DEF,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [8*HEADER_BYTES-1:0] job_header,
    output logic [8*TARGET_BYTES-1:0] job_target,
    output logic                      job_valid,
    input  logic                      job_ready,
    output logic                      frame_err,
    output logic [1:0]                err_code,
    output logic                      busy
);

    localparam int HDR_W     = 8 * HEADER_BYTES;
    localparam int TGT_W     = 8 * TARGET_BYTES;
    localparam int MAX_BYTES = max_int(HEADER_BYTES, TARGET_BYTES);
    localparam int CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HEADER_BYTES - 1);
    localparam logic [CNT_W-1:0] TGT_LAST = CNT_W'(TARGET_BYTES - 1);

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [HDR_W-1:0] job_header_q;
    logic [TGT_W-1:0] job_target_q;
    logic             job_valid_q;
    logic             frame_err_q;
    logic [1:0]       err_code_q;

    logic             in_frame;
    logic             tmo_expired;
    logic             sync_seen;

    assign in_frame  = (state_q == ST_HDR) || (state_q == ST_TGT) || (state_q == ST_CSUM);
    assign sync_seen = (state_q == ST_IDLE) && rx_valid && (rx_data == SYNC_BYTE);

    byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_byte_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (rx_valid || !in_frame),
        .en_i      (in_frame),
        .expired_o (tmo_expired)
    );

`ifdef HDR_RX_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] csum_total;

    assign csum_total = sum_q + rx_data;

    // Running 8-bit sum of header and target bytes, restarted on SYNC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (sync_seen) begin
            sum_q <= '0;
        end else if (rx_valid && ((state_q == ST_HDR) || (state_q == ST_TGT))) begin
            sum_q <= sum_q + rx_data;
        end
    end
`endif

    // Frame FSM with registered job/error outputs; frame_err defaults low so
    // every error is a single-cycle pulse while err_code keeps its last value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            job_header_q <= '0;
            job_target_q <= '0;
            job_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sync_seen) begin
                        state_q <= ST_HDR;
                        cnt_q   <= '0;
                    end
                end
                ST_HDR: begin
                    if (rx_valid) begin
                        job_header_q <= (job_header_q << 8) | HDR_W'(rx_data);
                        if (cnt_q == HDR_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_TGT;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (tmo_expired) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                    end
                end
                ST_TGT: begin
                    if (rx_valid) begin
                        job_target_q <= (job_target_q << 8) | TGT_W'(rx_data);
                        if (cnt_q == TGT_LAST) begin
                            cnt_q <= '0;
`ifdef HDR_RX_CHECKSUM_EN
                            state_q <= ST_CSUM;
`else
                            state_q     <= ST_HOLD;
                            job_valid_q <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (tmo_expired) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                    end
                end
`ifdef HDR_RX_CHECKSUM_EN
                ST_CSUM: begin
                    if (rx_valid) begin
                        if (csum_total == 8'h00) begin
                            state_q     <= ST_HOLD;
                            job_valid_q <= 1'b1;
                        end else begin
                            state_q     <= ST_IDLE;
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CSUM;
                        end
                    end else if (tmo_expired) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                    end
                end
`endif
                ST_HOLD: begin
                    if (rx_valid) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= ERR_OVERRUN;
                    end
                    if (job_ready) begin
                        state_q     <= ST_IDLE;
                        job_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    job_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign job_header = job_header_q;
    assign job_target = job_target_q;
    assign job_valid  = job_valid_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_header_frame_rx.sv
// Directed bench for header_frame_rx with default 80/32 byte geometry and a
// short 100-cycle inter-byte timeout. Adapts to HDR_RX_CHECKSUM_EN.
module tb_header_frame_rx;

    localparam int HB  = 80;
    localparam int TB  = 32;
    localparam int TMO = 100;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [8*HB-1:0]   job_header;
    logic [8*TB-1:0]   job_target;
    logic              job_valid;
    logic              job_ready;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;

    int checks;
    int failures;
    int err_pulses;
    int pulses_saved;

    logic [7:0]      hdr_b [HB];
    logic [7:0]      tgt_b [TB];
    logic [8*HB-1:0] exp_hdr;
    logic [8*TB-1:0] exp_tgt;

    header_frame_rx #(
        .HEADER_BYTES   (HB),
        .TARGET_BYTES   (TB),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .job_header (job_header),
        .job_target (job_target),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
    end

    task automatic chk(input string tag, input logic [8*HB-1:0] obs, input logic [8*HB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Expected job vectors: first byte lands in the most significant byte
    task automatic build_exp();
        for (int i = 0; i < HB; i++) exp_hdr[8*(HB-1-i) +: 8] = hdr_b[i];
        for (int i = 0; i < TB; i++) exp_tgt[8*(TB-1-i) +: 8] = tgt_b[i];
    endtask

    // Full frame; bad adds an offset to the checksum byte when present
    task automatic send_frame(input string tag, input logic [7:0] bad);
        logic [7:0] s;
        s = 8'h00;
        send_byte(8'hA5);
        for (int i = 0; i < HB; i++) begin
            send_byte(hdr_b[i]);
            s = s + hdr_b[i];
        end
`ifdef HDR_RX_CHECKSUM_EN
        for (int i = 0; i < TB; i++) begin
            send_byte(tgt_b[i]);
            s = s + tgt_b[i];
        end
        chk({tag, "_valid_before_last"}, job_valid, 0);
        send_byte(8'(8'h00 - s) + bad);
`else
        for (int i = 0; i < TB - 1; i++) send_byte(tgt_b[i]);
        chk({tag, "_valid_before_last"}, job_valid, 0);
        send_byte(tgt_b[TB-1] + bad);
`endif
    endtask

    task automatic load_frame1();
        for (int i = 0; i < HB; i++) hdr_b[i] = 8'(i);
        for (int i = 0; i < TB; i++) tgt_b[i] = 8'hFF;
        build_exp();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        err_pulses = 0;
        reset      = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        job_ready  = 1'b0;
        idle_cycles(3);

        chk("rst_header", job_header, 0);
        chk("rst_target", job_target, 0);
        chk("rst_valid", job_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        idle_cycles(2);

        // Junk before sync is ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        chk("junk_busy", busy, 0);
        chk("junk_err", frame_err, 0);

        // Good frame: header 00..4F, target all FF
        load_frame1();
        send_frame("f1", 8'h00);
        chk("f1_valid", job_valid, 1);
        chk("f1_hdr_msb", job_header[639:632], 8'h00);
        chk("f1_hdr_lsb", job_header[7:0], 8'h4F);
        chk("f1_hdr", job_header, exp_hdr);
        chk("f1_tgt", job_target, {(8*TB){1'b1}});
        chk("f1_busy", busy, 1);
        chk("f1_err", frame_err, 0);

        // Backpressure then overrun
        idle_cycles(3);
        chk("hold_valid", job_valid, 1);
        send_byte(8'hA5);
        chk("ovr_err", frame_err, 1);
        chk("ovr_code", err_code, 2'b11);
        chk("ovr_valid", job_valid, 1);
        chk("ovr_hdr", job_header, exp_hdr);
        chk("ovr_busy", busy, 1);
        idle_cycles(1);
        chk("ovr_pulse_end", frame_err, 0);
        chk("ovr_code_hold", err_code, 2'b11);

        job_ready = 1'b1;
        idle_cycles(1);
        job_ready = 1'b0;
        chk("acc_valid", job_valid, 0);
        chk("acc_busy", busy, 0);

        // Second frame with SYNC values embedded as data
        for (int i = 0; i < HB; i++) hdr_b[i] = 8'(i * 3 + 7);
        hdr_b[5] = 8'hA5;
        for (int i = 0; i < TB; i++) tgt_b[i] = 8'hA5 ^ 8'(i);
        build_exp();
        send_frame("f2", 8'h00);
        chk("f2_valid", job_valid, 1);
        chk("f2_hdr", job_header, exp_hdr);
        chk("f2_tgt", job_target, exp_tgt);

        // Byte arriving in the same cycle as acceptance
        job_ready = 1'b1;
        send_byte(8'h33);
        job_ready = 1'b0;
        chk("acc_ovr_err", frame_err, 1);
        chk("acc_ovr_code", err_code, 2'b11);
        chk("acc_ovr_valid", job_valid, 0);
        chk("acc_ovr_busy", busy, 0);
        idle_cycles(1);

`ifdef HDR_RX_CHECKSUM_EN
        // Checksum error then recovery
        load_frame1();
        send_frame("cs_bad", 8'h01);
        chk("cs_err", frame_err, 1);
        chk("cs_code", err_code, 2'b10);
        chk("cs_valid", job_valid, 0);
        chk("cs_busy", busy, 0);
        send_frame("cs_good", 8'h00);
        chk("cs_good_valid", job_valid, 1);
        chk("cs_good_hdr", job_header, exp_hdr);
        job_ready = 1'b1;
        idle_cycles(1);
        job_ready = 1'b0;
        chk("cs_acc_valid", job_valid, 0);
`endif

        // Timeout after 10 header bytes
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        idle_cycles(TMO - 1);
        chk("tmo_early_err", frame_err, 0);
        chk("tmo_early_busy", busy, 1);
        idle_cycles(1);
        chk("tmo_err", frame_err, 1);
        chk("tmo_code", err_code, 2'b01);
        chk("tmo_busy", busy, 0);
        idle_cycles(1);
        chk("tmo_pulse_end", frame_err, 0);

        // Byte on the expiry cycle wins and restarts the idle count
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        idle_cycles(TMO - 1);
        send_byte(8'h55);
        chk("race_err", frame_err, 0);
        chk("race_busy", busy, 1);
        idle_cycles(TMO);
        chk("race_tmo_err", frame_err, 1);
        chk("race_tmo_busy", busy, 0);
        idle_cycles(1);

        // Reset mid-frame discards silently
        load_frame1();
        pulses_saved = err_pulses;
        send_byte(8'hA5);
        for (int i = 0; i < 40; i++) send_byte(hdr_b[i]);
        reset = 1'b1;
        idle_cycles(2);
        chk("mid_rst_header", job_header, 0);
        chk("mid_rst_target", job_target, 0);
        chk("mid_rst_valid", job_valid, 0);
        chk("mid_rst_err", frame_err, 0);
        chk("mid_rst_code", err_code, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b0;
        idle_cycles(2);
        chk("mid_rst_no_pulse", err_pulses, pulses_saved);

        send_frame("f3", 8'h00);
        chk("f3_valid", job_valid, 1);
        chk("f3_hdr", job_header, exp_hdr);
        chk("f3_tgt", job_target, exp_tgt);
        job_ready = 1'b1;
        idle_cycles(1);
        job_ready = 1'b0;
        chk("f3_acc_valid", job_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/header_frame_rx.md
# header_frame_rx

Upstream framing stage between the UART receiver and the mining core. It parses the host byte stream into mining jobs: a sync byte, an 80-byte block header, a 32-byte target and an optional checksum. Each completed frame is presented as a single parallel job (header plus target) on a valid/ready handshake. Malformed, stalled or overrunning frames are discarded and reported on an error strobe.

## Interface
- `HEADER_BYTES`, default 80: block header length in bytes.
- `TARGET_BYTES`, default 32: target length in bytes.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 50000: maximum idle clocks between bytes inside a frame.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `job_header`  out  8*HEADER_BYTES  assembled header; first header byte is in bits [639:632].
- `job_target`  out  8*TARGET_BYTES  assembled target; first target byte is the MSB byte (big-endian).
- `job_valid`  out  1  job available; held until accepted.
- `job_ready`  in  1  consumer accepts the job when `job_valid && job_ready`.
- `frame_err`  out  1  one-cycle error strobe.
- `err_code`  out  2  cause of the error: 01 timeout, 10 checksum, 11 overrun. Valid with `frame_err`, holds its last value otherwise.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State machine states: IDLE, HDR, TGT, CSUM (only with checksum enabled), HOLD.
- IDLE
  - `rx_valid` with `rx_data == SYNC_BYTE` moves to HDR, clears the byte counter and the sum.
  - Any other byte is ignored silently.
- HDR
  - Each byte is shifted into `job_header` from the MSB end.
  - After HEADER_BYTES bytes, the byte counter resets and the state moves to TGT.
  - Bytes equal to SYNC_BYTE are treated as data here; there is no resync.
- TGT
  - Same shifting as HDR, into `job_target`.
  - After TARGET_BYTES bytes, moves to CSUM if enabled, otherwise HOLD.
- CSUM
  - The frame is good if (sum of all header and target bytes + checksum byte) mod 256 == 0. A good frame moves to HOLD.
  - A bad frame returns to IDLE with `frame_err` and code 10.
- HOLD
  - `job_valid` = 1. `job_header` and `job_target` are stable.
  - `job_ready` returns the block to IDLE the next cycle.
  - Any `rx_valid` in HOLD, including a cycle where `job_ready` is also high, drops the byte and pulses `frame_err` with code 11. The state is unchanged by the dropped byte.
- Timeout
  - In HDR, TGT or CSUM, the idle counter increments every cycle without `rx_valid` and clears on `rx_valid`.
  - Reaching TIMEOUT_CYCLES forces IDLE with `frame_err` and code 01.
  - No timeout applies in IDLE or HOLD.
- Simultaneous timeout expiry and `rx_valid`: the byte wins and the counter clears.
- The byte counter is sized by clog2 of the larger of HEADER_BYTES and TARGET_BYTES. The sum is an 8-bit wrapping accumulator. The idle counter is clog2(TIMEOUT_CYCLES+1) bits and saturates.
- Reset mid-frame: the partial frame is discarded; no error is reported.

## Timing
- Reset values: `job_header` 0, `job_target` 0, `job_valid` 0, `frame_err` 0, `err_code` 00, `busy` 0. State is IDLE and all counters are 0.
- `job_valid` rises one clock after the `rx_valid` of the last byte (the checksum byte, or the last target byte when checksum is disabled).
- Acceptance: `job_valid` falls the cycle after `job_valid && job_ready`. A sync byte is accepted from that cycle onward.
- `frame_err` is registered and is high for exactly one cycle per event.
- Back-to-back `rx_valid` on consecutive cycles is supported; there is no throughput limit.

## Configuration
- `HDR_RX_CHECKSUM_EN` defined:
  - The CSUM state and the 8-bit sum logic are present.
  - Frame length is 1+HEADER_BYTES+TARGET_BYTES+1 bytes.
- `HDR_RX_CHECKSUM_EN` not defined:
  - No checksum byte; TGT goes directly to HOLD.
  - Error code 10 never occurs.
  - Frame length is 1+HEADER_BYTES+TARGET_BYTES bytes.

## Structure
- Shared package (`miner_pkg`) holds:
  - the state enum;
  - the `err_code` constants `ERR_TIMEOUT`, `ERR_CSUM`, `ERR_OVERRUN`;
  - the default values for SYNC_BYTE, HEADER_BYTES and TARGET_BYTES.
- One sub-module, `byte_timeout`: the idle counter with clear, enable and an expiry output. It is reusable by the UART response stage.
- Header and target shift registers stay in the top level of this block.

## Test plan
- Good frame, checksum enabled: A5, header bytes 00..4F, target 32×FF, checksum = (−sum) mod 256 → `job_valid` 1 cycle after the checksum byte; `job_header[639:632]`=00, `[7:0]`=4F; `job_target` all ones.
- Checksum error: same frame with the checksum byte +1 → `frame_err` with code 10, `job_valid` stays 0, `busy` drops; a following correct frame is accepted.
- Timeout: A5 plus 10 header bytes, then silence for TIMEOUT_CYCLES (use 100 in the bench) → `frame_err` with code 01 exactly 100 cycles after the last byte; state IDLE.
- Overrun and backpressure: good frame with `job_ready` held 0, then send A5 → `frame_err` with code 11 and the job unchanged; raise `job_ready` → `job_valid` falls next cycle; the next frame is accepted.
- Junk before sync and reset mid-frame: bytes 00 FF 12 then a good frame → accepted normally. Assert `reset` after 40 header bytes → all outputs at reset values and no `frame_err`.
- Checksum disabled build: frame of A5 + 112 bytes → `job_valid` 1 cycle after the last target byte.
